contactor_drive_e: RTL



---
 rtl/contactor_drive_e.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/contactor_drive_e.sv
// -----------------------------------------------------------------------------
// contactor_drive_e
//   Supervised coil driver for contactor E in the ring interlock circuit.
//   Takes the combinational E permit and the operator close command, drives
//   the coil through a small state machine, debounces the raw auxiliary
//   contact and hands the clean feedback back to the interlock matrix.
//   Detects close timeout, open timeout / welded contacts and unexpected
//   drop-out while closed.
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_cmd_close    level request to close (synchronous to i_clk)
//   i_permit       interlock permit, 1 = closing allowed (synchronous)
//   i_aux_fb       raw asynchronous auxiliary contact, 1 = closed
//   i_fault_clr    single-cycle fault acknowledge
//   o_coil         coil drive, 1 = energise
//   o_fb_stable    debounced auxiliary feedback
//   o_state        OPEN=0 CLOSING=1 CLOSED=2 OPENING=3 FAULT=4
//   o_fault        high while in FAULT
//   o_fault_code   00 none, 01 close timeout, 10 open timeout/welded,
//                  11 unexpected drop-out
//   o_op_count     (CONTACTOR_STATS_EN) CLOSING->CLOSED count, saturating
//   o_trip_count   (CONTACTOR_STATS_EN) FAULT entry count, saturating
//
// Build option
//   CONTACTOR_STATS_EN  adds the operation / trip statistics counters.
//
// States
//   state    | meaning
//   OPEN     | coil off, contactor open, waiting for close request
//   CLOSING  | coil on, waiting for debounced feedback
//   CLOSED   | coil on, feedback confirmed
//   OPENING  | coil off, waiting for feedback to drop
//   FAULT    | coil off, code latched until acknowledged
// -----------------------------------------------------------------------------
module contactor_drive_e #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CLOSE_TIMEOUT   = 1000,
  parameter int OPEN_TIMEOUT    = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_close,
  input  logic       i_permit,
  input  logic       i_aux_fb,
  input  logic       i_fault_clr,
  output logic       o_coil,
  output logic       o_fb_stable,
  output logic [2:0] o_state,
  output logic       o_fault,
  output logic [1:0] o_fault_code
`ifdef CONTACTOR_STATS_EN
  ,
  output logic [15:0] o_op_count,
  output logic [7:0]  o_trip_count
`endif
);

  typedef enum logic [2:0] {
    ST_OPEN    = 3'd0,
    ST_CLOSING = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_OPENING = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The toggle happens on the edge that would bring the count to
  // DEBOUNCE_CYCLES, giving exactly DEBOUNCE_CYCLES mismatching samples.
  localparam logic [DB_W-1:0]  DB_TC    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLOSE_TC = CNT_W'(CLOSE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OPEN_TC  = CNT_W'(OPEN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMR_MAX  = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Feedback synchroniser and debounce
  // ---------------------------------------------------------------------------
  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            fb_q, fb_d;

  always_comb begin
    db_cnt_d = '0;
    fb_d     = fb_q;
    if (sync2_q != fb_q) begin
      if (db_cnt_q == DB_TC) begin
        fb_d     = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      fb_q     <= 1'b0;
    end else begin
      sync1_q  <= i_aux_fb;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      fb_q     <= fb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Supervisory state machine
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       code_q, code_d;
  logic             coil_q, coil_d;
  logic             fault_q, fault_d;
  logic             release_req;

  assign release_req = !i_permit || !i_cmd_close;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_OPEN: begin
        // Feedback while the coil is off means welded contacts.
        if (fb_q) begin
          state_d = ST_FAULT;
          code_d  = 2'b10;
        end else if (i_cmd_close && i_permit) begin
          state_d = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        if (release_req) begin
          state_d = ST_OPENING;
        end else if (fb_q) begin
          state_d = ST_CLOSED;
        end else if (timer_q == CLOSE_TC) begin
          state_d = ST_FAULT;
          code_d  = 2'b01;
        end
      end
      ST_CLOSED: begin
        if (release_req) begin
          state_d = ST_OPENING;
        end else if (!fb_q) begin
          state_d = ST_FAULT;
          code_d  = 2'b11;
        end
      end
      ST_OPENING: begin
        if (!fb_q) begin
          state_d = ST_OPEN;
        end else if (timer_q == OPEN_TC) begin
          state_d = ST_FAULT;
          code_d  = 2'b10;
        end
      end
      ST_FAULT: begin
        if (i_fault_clr && !i_cmd_close && !fb_q) begin
          state_d = ST_OPEN;
          code_d  = 2'b00;
        end
      end
      default: begin
        state_d = ST_OPEN;
        code_d  = 2'b00;
      end
    endcase

    // Coil and fault flags are derived from the next state so they change
    // on the same edge as the state register.
    coil_d  = (state_d == ST_CLOSING) || (state_d == ST_CLOSED);
    fault_d = (state_d == ST_FAULT);

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == TMR_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_OPEN;
      timer_q <= '0;
      code_q  <= 2'b00;
      coil_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      coil_q  <= coil_d;
      fault_q <= fault_d;
    end
  end

  assign o_coil       = coil_q;
  assign o_fb_stable  = fb_q;
  assign o_state      = state_q;
  assign o_fault      = fault_q;
  assign o_fault_code = code_q;

`ifdef CONTACTOR_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics; deliberately untouched by the fault acknowledge.
  // ---------------------------------------------------------------------------
  logic [15:0] op_cnt_q;
  logic [7:0]  trip_cnt_q;
  logic        op_evt, trip_evt;

  assign op_evt   = (state_q == ST_CLOSING) && (state_d == ST_CLOSED);
  assign trip_evt = (state_q != ST_FAULT) && (state_d == ST_FAULT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_cnt_q   <= '0;
      trip_cnt_q <= '0;
    end else begin
      if (op_evt && (op_cnt_q != 16'hFFFF)) begin
        op_cnt_q <= op_cnt_q + 1'b1;
      end
      if (trip_evt && (trip_cnt_q != 8'hFF)) begin
        trip_cnt_q <= trip_cnt_q + 1'b1;
      end
    end
  end

  assign o_op_count   = op_cnt_q;
  assign o_trip_count = trip_cnt_q;
`endif

endmodule
